dram_cmd_gen: RTL and testbench

DRAM_CMD_GEN -- requirements
Module: dram_cmd_gen

---
 rtl/dram_pkg.sv | 46 ++++
 rtl/row_table.sv | 65 ++++++
 rtl/dram_cmd_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_dram_cmd_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg
// Shared types and timing defaults for the DRAM command generator.
//   cmd_t   : 3-bit DRAM command encoding driven on cmd.
//   req_t   : request fields latched on accept.
//   tRP/tRCD/tRFC : default timing in controller clock cycles.
//   bank_idx() : builds the {rank,BG,bank} open-row table index.
package dram_pkg;

  localparam int ROW_BITS    = 15;
  localparam int COLUMN_BITS = 10;
  localparam int BG_BITS     = 2;
  localparam int BANK_BITS   = 2;
  localparam int IDX_BITS    = 1 + BG_BITS + BANK_BITS;
  localparam int NUM_ENTRIES = 1 << IDX_BITS;
  localparam int CNT_BITS    = 9;

  localparam int tRP  = 16;
  localparam int tRCD = 16;
  localparam int tRFC = 280;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_t;

  typedef struct packed {
    logic                   write;
    logic                   rank;
    logic [BG_BITS-1:0]     bg;
    logic [BANK_BITS-1:0]   bank;
    logic [ROW_BITS-1:0]    row;
    logic [COLUMN_BITS-1:0] col;
  } req_t;

  function automatic logic [IDX_BITS-1:0] bank_idx(input logic rank,
                                                   input logic [BG_BITS-1:0] bg,
                                                   input logic [BANK_BITS-1:0] bank);
    return {rank, bg, bank};
  endfunction

endpackage

// File: rtl/row_table.sv
// row_table
// Open-row table: one entry per {rank,BG,bank}, each holding an open bit and
// the currently open row.
//   clk, rst_n          : clock, asynchronous active-low reset (clears open bits)
//   rd_idx              : read address; rd_open/rd_row are registered (valid next cycle)
//   wr_en/wr_idx        : write port; wr_open sets/clears the open bit,
//   wr_open/wr_row        wr_row is stored only when opening
//   clear_all           : clears every open bit (refresh precharge-all)
//   any_open            : at least one entry is open
module row_table
  import dram_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_open,
  output logic [ROW_BITS-1:0] rd_row,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_open,
  input  logic [ROW_BITS-1:0] wr_row,
  input  logic                clear_all,
  output logic                any_open
);

  logic [NUM_ENTRIES-1:0] open_reg;
  logic [ROW_BITS-1:0]    row_mem [NUM_ENTRIES];
  logic                   rd_open_reg;
  logic [ROW_BITS-1:0]    rd_row_reg;

  // Open bits live in flops so they can be cleared in one cycle and on reset.
  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_open
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        open_reg[gi] <= 1'b0;
      end else if (clear_all) begin
        open_reg[gi] <= 1'b0;
      end else if (wr_en && (wr_idx == IDX_BITS'(gi))) begin
        open_reg[gi] <= wr_open;
      end
    end
  end

  // Row storage never needs clearing: an entry's row is only trusted while
  // its open bit is set, so this can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en && wr_open) begin
      row_mem[wr_idx] <= wr_row;
    end
    rd_row_reg <= row_mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_open_reg <= 1'b0;
    end else begin
      rd_open_reg <= open_reg[rd_idx];
    end
  end

  assign rd_open  = rd_open_reg;
  assign rd_row   = rd_row_reg;
  assign any_open = |open_reg;

endmodule

// File: rtl/dram_cmd_gen.sv
// dram_cmd_gen
// Turns decoded read/write requests into DRAM ACT/PRE/RD/WR commands using an
// open-row table, and runs the refresh sequence (PREA x2, REF x2, tRFC wait).
//   CLK, nRST           : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake; req_* fields latched on accept
//   ref_req / ref_done  : refresh request (level) / completion pulse
//   cmd_valid, cmd, cmd_rank, cmd_BG, cmd_bank, cmd_row, cmd_col : command bus
//   req_done            : pulses with the RD/WR that completes a request
module dram_cmd_gen
  import dram_pkg::*;
#(
  parameter int tRP  = dram_pkg::tRP,
  parameter int tRCD = dram_pkg::tRCD,
  parameter int tRFC = dram_pkg::tRFC
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic                   req_rank,
  input  logic [BG_BITS-1:0]     req_BG,
  input  logic [BANK_BITS-1:0]   req_bank,
  input  logic [ROW_BITS-1:0]    req_row,
  input  logic [COLUMN_BITS-1:0] req_col,
  input  logic                   ref_req,
  output logic                   ref_done,
  output logic                   cmd_valid,
  output cmd_t                   cmd,
  output logic                   cmd_rank,
  output logic [BG_BITS-1:0]     cmd_BG,
  output logic [BANK_BITS-1:0]   cmd_bank,
  output logic [ROW_BITS-1:0]    cmd_row,
  output logic [COLUMN_BITS-1:0] cmd_col,
  output logic                   req_done
);

  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_CHECK        = 4'd1;
  localparam logic [3:0] ST_PRE          = 4'd2;
  localparam logic [3:0] ST_WAIT_RP      = 4'd3;
  localparam logic [3:0] ST_ACT          = 4'd4;
  localparam logic [3:0] ST_WAIT_RCD     = 4'd5;
  localparam logic [3:0] ST_RW           = 4'd6;
  localparam logic [3:0] ST_REF_PREA     = 4'd7;
  localparam logic [3:0] ST_REF_WAIT_RP  = 4'd8;
  localparam logic [3:0] ST_REF          = 4'd9;
  localparam logic [3:0] ST_REF_WAIT_RFC = 4'd10;

  localparam logic [CNT_BITS-1:0] RP_LOAD  = CNT_BITS'(tRP - 1);
  localparam logic [CNT_BITS-1:0] RCD_LOAD = CNT_BITS'(tRCD - 1);
  localparam logic [CNT_BITS-1:0] RFC_LOAD = CNT_BITS'(tRFC - 1);

  logic [3:0]          state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                phase_reg, phase_next;   // rank select for the paired PREA/REF cycles
  req_t                req_reg, req_next;

  logic                accept;
  logic                tbl_rd_open;
  logic [ROW_BITS-1:0] tbl_rd_row;
  logic                tbl_any_open;
  logic [IDX_BITS-1:0] tbl_rd_idx;
  logic [IDX_BITS-1:0] cur_idx;
  logic                tbl_wr_en;
  logic                tbl_clear_all;

  assign req_ready = nRST && (state_reg == ST_IDLE) && !ref_req;
  assign accept    = req_valid && req_ready;
  assign cur_idx   = bank_idx(req_reg.rank, req_reg.bg, req_reg.bank);

  // Look up the incoming request while idle so the registered table read is
  // ready exactly when CHECK needs it.
  assign tbl_rd_idx    = (state_reg == ST_IDLE) ? bank_idx(req_rank, req_BG, req_bank) : cur_idx;
  assign tbl_wr_en     = (state_reg == ST_PRE) || (state_reg == ST_ACT);
  assign tbl_clear_all = (state_reg == ST_REF_PREA);

  row_table u_row_table (
    .clk       (CLK),
    .rst_n     (nRST),
    .rd_idx    (tbl_rd_idx),
    .rd_open   (tbl_rd_open),
    .rd_row    (tbl_rd_row),
    .wr_en     (tbl_wr_en),
    .wr_idx    (cur_idx),
    .wr_open   (state_reg == ST_ACT),
    .wr_row    (req_reg.row),
    .clear_all (tbl_clear_all),
    .any_open  (tbl_any_open)
  );

  // Next-state logic. The shared counter is loaded when the timed command is
  // issued (PRE, ACT, last PREA) so the following command lands exactly
  // tRP/tRCD cycles later; REF_WAIT_RFC itself lasts tRFC cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg != '0) ? cnt_reg - CNT_BITS'(1) : '0;
    phase_next = phase_reg;
    req_next   = req_reg;

    case (state_reg)
      ST_IDLE: begin
        phase_next = 1'b0;
        if (ref_req) begin
          state_next = tbl_any_open ? ST_REF_PREA : ST_REF;
        end else if (accept) begin
          req_next.write = req_write;
          req_next.rank  = req_rank;
          req_next.bg    = req_BG;
          req_next.bank  = req_bank;
          req_next.row   = req_row;
          req_next.col   = req_col;
          state_next     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (tbl_rd_open && (tbl_rd_row == req_reg.row)) begin
          state_next = ST_RW;
        end else if (tbl_rd_open) begin
          state_next = ST_PRE;
          cnt_next   = RP_LOAD;
        end else begin
          state_next = ST_ACT;
          cnt_next   = RCD_LOAD;
        end
      end
      ST_PRE:     state_next = ST_WAIT_RP;
      ST_WAIT_RP: begin
        if (cnt_reg == '0) begin
          state_next = ST_ACT;
          cnt_next   = RCD_LOAD;
        end
      end
      ST_ACT:      state_next = ST_WAIT_RCD;
      ST_WAIT_RCD: begin
        if (cnt_reg == '0) begin
          state_next = ST_RW;
        end
      end
      ST_RW:       state_next = ST_IDLE;
      ST_REF_PREA: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
          cnt_next   = RP_LOAD;
        end else begin
          phase_next = 1'b0;
          state_next = ST_REF_WAIT_RP;
        end
      end
      ST_REF_WAIT_RP: begin
        if (cnt_reg == '0) begin
          state_next = ST_REF;
          phase_next = 1'b0;
        end
      end
      ST_REF: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          state_next = ST_REF_WAIT_RFC;
          cnt_next   = RFC_LOAD;
        end
      end
      ST_REF_WAIT_RFC: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
      req_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      req_reg   <= req_next;
    end
  end

  // Command bus is a pure function of state; address fields stay 0 on NOP.
  always_comb begin
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    cmd_rank  = 1'b0;
    cmd_BG    = '0;
    cmd_bank  = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    case (state_reg)
      ST_PRE: begin
        cmd_valid = 1'b1;
        cmd       = CMD_PRE;
        cmd_rank  = req_reg.rank;
        cmd_BG    = req_reg.bg;
        cmd_bank  = req_reg.bank;
      end
      ST_ACT: begin
        cmd_valid = 1'b1;
        cmd       = CMD_ACT;
        cmd_rank  = req_reg.rank;
        cmd_BG    = req_reg.bg;
        cmd_bank  = req_reg.bank;
        cmd_row   = req_reg.row;
      end
      ST_RW: begin
        cmd_valid = 1'b1;
        cmd       = req_reg.write ? CMD_WR : CMD_RD;
        cmd_rank  = req_reg.rank;
        cmd_BG    = req_reg.bg;
        cmd_bank  = req_reg.bank;
        cmd_col   = req_reg.col;
      end
      ST_REF_PREA: begin
        cmd_valid = 1'b1;
        cmd       = CMD_PREA;
        cmd_rank  = phase_reg;
      end
      ST_REF: begin
        cmd_valid = 1'b1;
        cmd       = CMD_REF;
        cmd_rank  = phase_reg;
      end
      default: ;
    endcase
  end

  assign req_done = (state_reg == ST_RW);
  assign ref_done = (state_reg == ST_REF_WAIT_RFC) && (cnt_reg == '0);

endmodule

// File: tb/tb_dram_cmd_gen.sv
// tb_dram_cmd_gen
// Directed bench for dram_cmd_gen: closed-bank read, hit write, conflict,
// refresh with and without open banks, and reset in the middle of a request.
// All expected cycles are hand-derived from the tRP/tRCD/tRFC defaults.
module tb_dram_cmd_gen;
  import dram_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_rank = 1'b0;
  logic [1:0]  req_BG = 2'd0;
  logic [1:0]  req_bank = 2'd0;
  logic [14:0] req_row = 15'd0;
  logic [9:0]  req_col = 10'd0;
  logic        ref_req = 1'b0;
  logic        ref_done;
  logic        cmd_valid;
  cmd_t        cmd;
  logic        cmd_rank;
  logic [1:0]  cmd_BG;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        req_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  dram_cmd_gen dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_rank  (req_rank),
    .req_BG    (req_BG),
    .req_bank  (req_bank),
    .req_row   (req_row),
    .req_col   (req_col),
    .ref_req   (ref_req),
    .ref_done  (ref_done),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_rank  (cmd_rank),
    .cmd_BG    (cmd_BG),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .req_done  (req_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to the next issued command (bounded) and compare its opcode.
  task automatic wait_cmd(input string tag, input cmd_t want, input int budget, output int at);
    logic [31:0] got;
    got = 32'hDEAD;
    at  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (cmd_valid) begin
        got = 32'(cmd);
        at  = cyc;
        break;
      end
    end
    check(tag, got, 32'(want));
  endtask

  // Present a request from a negedge; returns at the negedge of the CHECK cycle.
  task automatic issue_req(input string tag, input logic w, input logic r, input logic [1:0] bg,
                           input logic [1:0] bank, input logic [14:0] row, input logic [9:0] col,
                           output int chk_at);
    req_write = w; req_rank = r; req_BG = bg; req_bank = bank; req_row = row; req_col = col;
    req_valid = 1'b1;
    chk_at = -1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        @(negedge CLK);
        chk_at = cyc;
        break;
      end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    // Scramble the inputs: the DUT must work from its latched copy.
    req_write = ~w; req_rank = ~r; req_BG = ~bg; req_bank = ~bank; req_row = ~row; req_col = ~col;
    check({tag, "_accepted"}, 32'(chk_at >= 0), 32'd1);
  endtask

  task automatic wait_ref_done(input string tag, output int at);
    logic noisy;
    noisy = 1'b0;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (ref_done) begin
        at = cyc;
        break;
      end
      if (cmd_valid) noisy = 1'b1;
    end
    check({tag, "_rfc_quiet"}, 32'(noisy), 32'd0);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc, ta, tr, tp, t0, t1, td;
    logic busy_seen;

    // ---- reset ----
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    nRST = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_cmd", 32'(cmd), 32'(CMD_NOP));

    // ---- refresh with nothing open: straight to REF ----
    @(negedge CLK);
    ref_req = 1'b1;
    wait_cmd("ref0_first_is_ref", CMD_REF, 4, t0);
    check("ref0_r0_rank", 32'(cmd_rank), 32'd0);
    wait_cmd("ref0_second_ref", CMD_REF, 4, t1);
    check("ref0_r1_rank", 32'(cmd_rank), 32'd1);
    check("ref0_r1_delay", 32'(t1 - t0), 32'd1);
    ref_req = 1'b0;
    wait_ref_done("ref0", td);
    check("ref0_done_delay", 32'(td - t1), 32'd280);
    @(negedge CLK);
    check("ref0_done_pulse", 32'(ref_done), 32'd0);
    check("ref0_back_idle", 32'(req_ready), 32'd1);

    // ---- closed bank read ----
    issue_req("rd_closed", 1'b0, 1'b0, 2'd1, 2'd2, 15'h0123, 10'h040, tc);
    wait_cmd("rd_closed_act", CMD_ACT, 4, ta);
    check("rd_closed_act_at", 32'(ta - tc), 32'd1);
    check("rd_closed_act_addr", {17'd0, cmd_rank, cmd_BG, cmd_bank, 10'd0}, {17'd0, 1'b0, 2'd1, 2'd2, 10'd0});
    check("rd_closed_act_row", 32'(cmd_row), 32'h0123);
    check("rd_closed_act_col0", 32'(cmd_col), 32'd0);
    wait_cmd("rd_closed_rd", CMD_RD, 20, tr);
    check("rd_closed_trcd", 32'(tr - ta), 32'd16);
    check("rd_closed_col", 32'(cmd_col), 32'h040);
    check("rd_closed_row0", 32'(cmd_row), 32'd0);
    check("rd_closed_done", 32'(req_done), 32'd1);
    @(negedge CLK);
    check("rd_closed_done_pulse", 32'(req_done), 32'd0);
    check("rd_closed_idle", 32'(req_ready), 32'd1);

    // ---- hit write ----
    issue_req("wr_hit", 1'b1, 1'b0, 2'd1, 2'd2, 15'h0123, 10'h048, tc);
    wait_cmd("wr_hit_wr", CMD_WR, 4, tr);
    check("wr_hit_at", 32'(tr - tc), 32'd1);
    check("wr_hit_col", 32'(cmd_col), 32'h048);
    check("wr_hit_bank", {30'd0, cmd_bank}, 32'd2);
    check("wr_hit_done", 32'(req_done), 32'd1);

    // ---- conflict, with a stray request held while busy ----
    @(negedge CLK);
    issue_req("conf", 1'b0, 1'b0, 2'd1, 2'd2, 15'h0456, 10'h010, tc);
    req_valid = 1'b1; req_row = 15'h7fff; req_rank = 1'b1; req_col = 10'h3ff;
    wait_cmd("conf_pre", CMD_PRE, 4, tp);
    check("conf_pre_at", 32'(tp - tc), 32'd1);
    check("conf_pre_addr", {29'd0, cmd_rank, cmd_BG}, {29'd0, 1'b0, 2'd1});
    wait_cmd("conf_act", CMD_ACT, 20, ta);
    check("conf_trp", 32'(ta - tp), 32'd16);
    check("conf_act_row", 32'(cmd_row), 32'h0456);
    busy_seen = req_ready;
    check("conf_busy_not_ready", 32'(busy_seen), 32'd0);
    req_valid = 1'b0;
    wait_cmd("conf_rd", CMD_RD, 20, tr);
    check("conf_trcd", 32'(tr - ta), 32'd16);
    check("conf_rd_col", 32'(cmd_col), 32'h010);
    check("conf_rd_rank", 32'(cmd_rank), 32'd0);

    // ---- refresh and request together: refresh wins ----
    @(negedge CLK);
    req_write = 1'b0; req_rank = 1'b1; req_BG = 2'd3; req_bank = 2'd1;
    req_row = 15'h2aaa; req_col = 10'h3ff;
    req_valid = 1'b1; ref_req = 1'b1;
    #1;
    check("refq_ready_blocked", 32'(req_ready), 32'd0);
    wait_cmd("refq_prea0", CMD_PREA, 4, t0);
    check("refq_prea0_rank", 32'(cmd_rank), 32'd0);
    wait_cmd("refq_prea1", CMD_PREA, 4, t1);
    check("refq_prea1_rank", 32'(cmd_rank), 32'd1);
    check("refq_prea1_at", 32'(t1 - t0), 32'd1);
    ref_req = 1'b0;
    wait_cmd("refq_ref0", CMD_REF, 20, t0);
    check("refq_ref0_trp", 32'(t0 - t1), 32'd16);
    check("refq_ref0_rank", 32'(cmd_rank), 32'd0);
    wait_cmd("refq_ref1", CMD_REF, 4, t1);
    check("refq_ref1_rank", 32'(cmd_rank), 32'd1);
    wait_ref_done("refq", td);
    check("refq_trfc", 32'(td - t1), 32'd280);
    @(negedge CLK);
    check("refq_ready_after", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    wait_cmd("refq_act", CMD_ACT, 4, ta);
    check("refq_act_at", 32'(ta - td), 32'd3);
    check("refq_act_addr", {28'd0, cmd_rank, cmd_BG, cmd_bank}, {28'd0, 1'b1, 2'd3, 2'd1});
    check("refq_act_row", 32'(cmd_row), 32'h2aaa);
    wait_cmd("refq_rd", CMD_RD, 20, tr);
    check("refq_rd_trcd", 32'(tr - ta), 32'd16);
    check("refq_rd_col", 32'(cmd_col), 32'h3ff);

    // ---- open another bank so a table clear is observable ----
    @(negedge CLK);
    issue_req("open_b3", 1'b0, 1'b0, 2'd0, 2'd3, 15'h0077, 10'h005, tc);
    wait_cmd("open_b3_act", CMD_ACT, 4, ta);
    wait_cmd("open_b3_rd", CMD_RD, 20, tr);

    // ---- reset during WAIT_RP ----
    @(negedge CLK);
    issue_req("rstmid", 1'b1, 1'b1, 2'd3, 2'd1, 15'h1555, 10'h001, tc);
    wait_cmd("rstmid_pre", CMD_PRE, 4, tp);
    repeat (5) @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("rstmid_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd0);
    busy_seen = 1'b0;
    repeat (16) begin
      @(negedge CLK);
      if (cmd_valid || req_done) busy_seen = 1'b1;
    end
    check("rstmid_silent", 32'(busy_seen), 32'd0);
    nRST = 1'b1;
    #1;
    check("rstmid_ready_release", 32'(req_ready), 32'd1);
    issue_req("retry", 1'b1, 1'b1, 2'd3, 2'd1, 15'h1555, 10'h001, tc);
    wait_cmd("retry_act_not_pre", CMD_ACT, 4, ta);
    check("retry_act_row", 32'(cmd_row), 32'h1555);
    wait_cmd("retry_wr", CMD_WR, 20, tr);
    check("retry_trcd", 32'(tr - ta), 32'd16);
    check("retry_done", 32'(req_done), 32'd1);

    // Bank opened before reset must now read as closed (ACT, not a hit WR).
    @(negedge CLK);
    issue_req("cleared", 1'b1, 1'b0, 2'd0, 2'd3, 15'h0077, 10'h006, tc);
    wait_cmd("cleared_act", CMD_ACT, 4, ta);
    wait_cmd("cleared_wr", CMD_WR, 20, tr);
    check("cleared_wr_col", 32'(cmd_col), 32'h006);

    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
